// File: rtl/pixel_pattern_pkg.sv
// Shared definitions for the animated background pattern generator:
// mode encodings, default colours and the mode sequencing order.
package pixel_pattern_pkg;

  // Number of selectable background patterns.
  localparam int NUM_MODES = 4;

  // Colour width the default constants below are sized for (RRGGBB).
  localparam int DEFAULT_COLOR_W = 6;

  // Pattern modes; the encoding matches the 2-bit mode_sel input.
  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_HBARS   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_e;

  // Default colour shown in SOLID mode (pure blue in RRGGBB).
  localparam logic [DEFAULT_COLOR_W-1:0] DEFAULT_SOLID_COLOR = 6'b000011;

  // Black and white at the default colour width.
  localparam logic [DEFAULT_COLOR_W-1:0] COLOR_BLACK = 6'b000000;
  localparam logic [DEFAULT_COLOR_W-1:0] COLOR_WHITE = 6'b111111;

  // Auto-cycle order: SOLID -> HBARS -> CHECKER -> SCROLL -> SOLID.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_SOLID:   nxt = MODE_HBARS;
      MODE_HBARS:   nxt = MODE_CHECKER;
      MODE_CHECKER: nxt = MODE_SCROLL;
      MODE_SCROLL:  nxt = MODE_SOLID;
      default:      nxt = MODE_SOLID;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pixel_pattern_gen_frame_timer.sv
// Frame timing for the pattern generator: detects the rising edge of
// vsync, counts frames and measures how long the current mode has been
// shown so the top level knows when to advance in auto-cycle mode.
module pixel_pattern_gen_frame_timer #(
  parameter int FRAME_W         = 10,
  parameter int FRAMES_PER_MODE = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               auto_cycle,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               mode_advance
);

  // Dwell counter only has to reach FRAMES_PER_MODE-1.
  localparam int DWELL_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(FRAMES_PER_MODE - 1);

  logic               vsync_d_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic               tick_s;
  logic               dwell_last_s;

  // Rising-edge detect: one tick per vsync pulse, however long vsync stays high.
  always_comb begin
    tick_s       = vsync & ~vsync_d_r;
    dwell_last_s = (dwell_cnt_r == DWELL_LAST);
  end

  // Delayed copy of vsync used by the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_r <= 1'b0;
    end else begin
      vsync_d_r <= vsync;
    end
  end

  // Free-running frame counter, wraps naturally at 2^FRAME_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= '0;
    end else if (tick_s) begin
      frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
    end
  end

  // Frames spent in the current mode; parked at zero whenever auto-cycling is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt_r <= '0;
    end else if (tick_s) begin
      if (auto_cycle && !dwell_last_s) begin
        dwell_cnt_r <= dwell_cnt_r + DWELL_W'(1);
      end else begin
        dwell_cnt_r <= '0;
      end
    end else if (!auto_cycle) begin
      dwell_cnt_r <= '0;
    end
  end

  assign frame_tick   = tick_s;
  assign frame_cnt    = frame_cnt_r;
  assign mode_advance = tick_s & auto_cycle & dwell_last_s;

endmodule

// File: rtl/pixel_pattern_gen.sv
// Animated background pattern generator. Chooses one of four patterns
// from the VGA timing inputs and registers the resulting pixel colour.
// Mode changes happen only at the start of a frame to avoid tearing.
module pixel_pattern_gen
  import pixel_pattern_pkg::*;
#(
  parameter int                 COLOR_W         = 6,
  parameter int                 POS_W           = 10,
  parameter int                 FRAME_W         = 10,
  parameter int                 FRAMES_PER_MODE = 128,
  parameter logic [COLOR_W-1:0] SOLID_COLOR     = COLOR_W'(DEFAULT_SOLID_COLOR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               visible,
  input  logic               auto_cycle,
  input  logic [1:0]         mode_sel,
  output logic [COLOR_W-1:0] vga_color
);

  localparam logic [COLOR_W-1:0] WHITE_C = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] BLACK_C = {COLOR_W{1'b0}};

  logic               frame_tick_s;
  logic               mode_advance_s;
  logic [FRAME_W-1:0] frame_cnt_s;
  mode_e              mode_r;
  logic [POS_W-1:0]   pos_sum_s;
  logic [POS_W-1:0]   pos_tmp_s;
  logic [COLOR_W-1:0] pattern_s;

  // hsync is part of the pin-compatible interface but carries no information here.
  logic unused_hsync_s;
  assign unused_hsync_s = hsync;

  pixel_pattern_gen_frame_timer #(
    .FRAME_W         (FRAME_W),
    .FRAMES_PER_MODE (FRAMES_PER_MODE)
  ) u_frame_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .auto_cycle   (auto_cycle),
    .frame_tick   (frame_tick_s),
    .frame_cnt    (frame_cnt_s),
    .mode_advance (mode_advance_s)
  );

  // Mode FSM: advances or follows mode_sel only on the frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_SOLID;
    end else if (frame_tick_s) begin
      if (auto_cycle) begin
        if (mode_advance_s) begin
          mode_r <= next_mode(mode_r);
        end
      end else begin
        mode_r <= mode_e'(mode_sel);
      end
    end
  end

  // Pattern selection from the current (pre-update) mode and frame count.
  always_comb begin
    pos_sum_s = hpos + POS_W'(frame_cnt_s);
    pos_tmp_s = '0;
    pattern_s = BLACK_C;
    case (mode_r)
      MODE_SOLID: begin
        pattern_s = SOLID_COLOR;
      end
      MODE_HBARS: begin
        pos_tmp_s = hpos >> 3'd4;
        pattern_s = COLOR_W'(pos_tmp_s);
      end
      MODE_CHECKER: begin
        if (hpos[5] ^ vpos[5]) begin
          pattern_s = WHITE_C;
        end else begin
          pattern_s = BLACK_C;
        end
      end
      MODE_SCROLL: begin
        pos_tmp_s = (pos_sum_s >> 3'd3) ^ (vpos >> 3'd3);
        pattern_s = COLOR_W'(pos_tmp_s);
      end
      default: begin
        pattern_s = BLACK_C;
      end
    endcase
  end

  // Output register: black outside the active area, one clock after the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_color <= '0;
    end else if (visible) begin
      vga_color <= pattern_s;
    end else begin
      vga_color <= BLACK_C;
    end
  end

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Scoreboard bench for pixel_pattern_gen: stimulus pushes the expected
// colour for each driven cycle, a monitor pops and compares after the edge.
module tb_pixel_pattern_gen;
  import pixel_pattern_pkg::*;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       hsync      = 1'b0;
  logic       vsync      = 1'b0;
  logic [9:0] hpos       = 10'd0;
  logic [9:0] vpos       = 10'd0;
  logic       visible    = 1'b0;
  logic       auto_cycle = 1'b1;
  logic [1:0] mode_sel   = 2'd0;
  logic [5:0] vga_color;

  typedef struct {
    logic       chk;
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   ticks_seen = 0;
  int   exp_frame  = 0;

  always #5 clk = ~clk;

  pixel_pattern_gen #(
    .COLOR_W         (6),
    .POS_W           (10),
    .FRAME_W         (10),
    .FRAMES_PER_MODE (4),
    .SOLID_COLOR     (6'b000011)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .hpos       (hpos),
    .vpos       (vpos),
    .visible    (visible),
    .auto_cycle (auto_cycle),
    .mode_sel   (mode_sel),
    .vga_color  (vga_color)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected output.
  task automatic step(input logic vs, input logic vis, input logic [9:0] h,
                      input logic [9:0] v, input logic chk, input logic [5:0] e,
                      input string n);
    exp_t ent;
    @(negedge clk);
    vsync   = vs;
    visible = vis;
    hpos    = h;
    vpos    = v;
    ent.chk  = chk;
    ent.exp  = e;
    ent.name = n;
    sb_q.push_back(ent);
    @(posedge clk);
  endtask

  // One vsync pulse (two cycles), unchecked; tracks the expected frame count.
  task automatic pulse();
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 6'd0, "pulse_hi");
    step(1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 6'd0, "pulse_lo");
    exp_frame = (exp_frame + 1) % 1024;
  endtask

  task automatic set_ctl(input logic a, input logic [1:0] m);
    @(negedge clk);
    auto_cycle = a;
    mode_sel   = m;
  endtask

  task automatic check_frame(input string n, input int e);
    @(negedge clk);
    check(n, 32'(dut.frame_cnt_s), 32'(e));
  endtask

  // Monitor: compare the registered colour just after each rising edge.
  always begin
    exp_t ent;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      if (ent.chk) check(ent.name, 32'(vga_color), 32'(ent.exp));
    end
  end

  // Count frame ticks as seen at each rising edge.
  always @(posedge clk) begin
    if (dut.frame_tick_s) ticks_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // Async reset before any clock edge
    #2 rst_n = 1'b0;
    visible = 1'b1;
    hpos    = 10'h050;
    #1 check("reset_value", 32'(vga_color), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 10'h050, 10'd0, 1'b1, 6'b000011, "solid_after_reset");

    // Blanking
    step(1'b0, 1'b0, 10'h050, 10'd0, 1'b1, 6'b000000, "blank");
    step(1'b0, 1'b1, 10'h050, 10'd0, 1'b1, 6'b000011, "unblank");

    // Auto cycle with 4 frames per mode
    repeat (3) pulse();
    step(1'b0, 1'b1, 10'h050, 10'd0, 1'b1, 6'b000011, "auto_still_solid");
    pulse();
    step(1'b0, 1'b1, 10'h035, 10'd0, 1'b1, 6'b000011, "hbars_0x35");
    step(1'b0, 1'b1, 10'h050, 10'd0, 1'b1, 6'b000101, "hbars_0x50");
    repeat (4) pulse();
    step(1'b0, 1'b1, 10'd32, 10'd0, 1'b1, 6'b111111, "auto_checker");
    repeat (8) pulse();
    step(1'b0, 1'b1, 10'h050, 10'd0, 1'b1, 6'b000011, "auto_wrap_solid");

    // Manual select changed mid-frame takes effect only at next tick
    set_ctl(1'b0, 2'd2);
    step(1'b0, 1'b1, 10'd32, 10'd0, 1'b1, 6'b000011, "manual_before_tick");
    step(1'b1, 1'b1, 10'd32, 10'd0, 1'b1, 6'b000011, "manual_tick_cycle");
    exp_frame = (exp_frame + 1) % 1024;
    step(1'b0, 1'b1, 10'd32, 10'd0, 1'b1, 6'b111111, "checker_32_0");
    step(1'b0, 1'b1, 10'd32, 10'd32, 1'b1, 6'b000000, "checker_32_32");
    step(1'b0, 1'b1, 10'd0, 10'd32, 1'b1, 6'b111111, "checker_0_32");

    // Scroll mode and frame counter wrap
    set_ctl(1'b0, 2'd3);
    pulse();
    while (exp_frame != 1023) pulse();
    check_frame("frame_1023", 1023);
    step(1'b0, 1'b1, 10'd8, 10'd0, 1'b1, 6'b000000, "scroll_f1023");
    step(1'b1, 1'b1, 10'd8, 10'd0, 1'b1, 6'b000000, "scroll_tick_old_frame");
    exp_frame = 0;
    step(1'b0, 1'b1, 10'd8, 10'd0, 1'b1, 6'b000001, "scroll_f0");
    step(1'b0, 1'b1, 10'h010, 10'h008, 1'b1, 6'b000011, "scroll_xor");
    check_frame("frame_wrap_0", 0);

    // vsync held high for 100 clocks gives one tick
    t0 = ticks_seen;
    repeat (100) step(1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 6'd0, "held_hi");
    step(1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 6'd0, "held_lo");
    exp_frame = 1;
    check("held_vsync_ticks", 32'(ticks_seen - t0), 32'd1);
    check_frame("held_vsync_frame", exp_frame);

    // Mid-frame async reset from SCROLL mode
    step(1'b0, 1'b1, 10'd8, 10'd0, 1'b1, 6'b000001, "pre_reset_scroll");
    #2 rst_n = 1'b0;
    #1 check("async_reset_midline", 32'(vga_color), 32'd0);
    check("reset_frame_cnt", 32'(dut.frame_cnt_s), 32'd0);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b1, 10'd8, 10'd0, 1'b1, 6'b000011, "solid_after_midreset");

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
